// File: rtl/xbar_pkg.sv
// Shared crossbar scheduler types, control-word field layout and the control-word pack helper.
package xbar_pkg;

  typedef enum logic [1:0] {IDLE, CFG, XFER} state_t;

  localparam int unsigned CTRL_MAX_BW = 64;
  localparam int unsigned WRITE_BIT   = 1;

  // Field positions, counted from the LSB of a bw-wide control word.
  function automatic int unsigned blk_lsb(input int unsigned bw, input int unsigned abw);
    return bw - abw;
  endfunction

  function automatic int unsigned wr_pos(input int unsigned bw, input int unsigned abw);
    return bw - abw - 1;
  endfunction

  function automatic int unsigned in_lsb(input int unsigned bw, input int unsigned abw,
                                         input int unsigned in_w);
    return bw - abw - 1 - in_w;
  endfunction

  function automatic int unsigned out_lsb(input int unsigned bw, input int unsigned abw,
                                          input int unsigned in_w, input int unsigned out_w);
    return bw - abw - 1 - in_w - out_w;
  endfunction

  function automatic logic [CTRL_MAX_BW-1:0] field(input int unsigned v, input int unsigned w);
    return CTRL_MAX_BW'(v) & ((CTRL_MAX_BW'(1) << w) - CTRL_MAX_BW'(1));
  endfunction

  function automatic logic [CTRL_MAX_BW-1:0] pack_ctrl(
    input int unsigned bw, input int unsigned abw,
    input int unsigned in_w, input int unsigned out_w,
    input int unsigned blk, input int unsigned in_sel, input int unsigned out_sel);
    logic [CTRL_MAX_BW-1:0] m;
    m = '0;
    m = m | (field(blk, abw) << blk_lsb(bw, abw));
    m = m | (CTRL_MAX_BW'(WRITE_BIT) << wr_pos(bw, abw));
    m = m | (field(in_sel, in_w) << in_lsb(bw, abw, in_w));
    m = m | (field(out_sel, out_w) << out_lsb(bw, abw, in_w, out_w));
    return m;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant and index, search starts at ptr, ptr advances on en.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] ptr;
  int unsigned      idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/xbar_route_scheduler.sv
// Round-robin route scheduler for the blocking crossbar: grant, write route, count burst, release.
// Optional idle timeout in XFER enabled by defining XBAR_SCHED_TIMEOUT_EN.
module xbar_route_scheduler
  import xbar_pkg::*;
#(
  parameter int unsigned BIT_WIDTH         = 32,
  parameter int unsigned N_INPUTS          = 2,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned ADDRESS_BIT_WIDTH = 4,
  parameter int unsigned BLOCK_ADDRESS     = 2,
  parameter int unsigned LEN_BITS          = 8
`ifdef XBAR_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT           = 255
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_INPUTS-1:0]                  req_val,
  output logic [N_INPUTS-1:0]                  req_rdy,
  input  logic [$clog2(N_OUTPUTS)-1:0]         req_dest [N_INPUTS],
  input  logic [LEN_BITS-1:0]                  req_len  [N_INPUTS],
  output logic [BIT_WIDTH-1:0]                 ctrl_msg,
  output logic                                 ctrl_val,
  input  logic                                 ctrl_rdy,
  input  logic [N_OUTPUTS-1:0]                 out_fire,
  output logic [N_INPUTS-1:0]                  done,
`ifdef XBAR_SCHED_TIMEOUT_EN
  output logic                                 timeout,
`endif
  output logic                                 busy
);

  localparam int unsigned IN_W  = $clog2(N_INPUTS);
  localparam int unsigned OUT_W = $clog2(N_OUTPUTS);

  state_t               state, state_nxt;
  logic [LEN_BITS-1:0]  cnt;
  logic [IN_W-1:0]      in_sel;
  logic [OUT_W-1:0]     out_sel;
  logic [N_INPUTS-1:0]  grant;
  logic [IN_W-1:0]      grant_idx;
  logic                 any_req;
  logic                 arb_en;
  logic [(1<<OUT_W)-1:0] fire_pad;
  logic                 fire;
  logic                 last;
  logic                 abort;

  xbar_rr_arbiter #(
    .N     (N_INPUTS),
    .IDX_W (IN_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_val),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  // Pad out_fire to a power of two so an out-of-range out_sel simply never sees a fire.
  always_comb begin
    fire_pad                = '0;
    fire_pad[N_OUTPUTS-1:0] = out_fire;
  end

  assign fire = (state == XFER) && fire_pad[out_sel];
  assign last = fire && (cnt == LEN_BITS'(1));

`ifdef XBAR_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;

  assign abort = (state == XFER) && !fire && (idle_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= abort;
      if (state != XFER || fire || abort) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_rdy   = '0;
    ctrl_val  = 1'b0;
    ctrl_msg  = '0;
    arb_en    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_rdy = grant;
        arb_en  = any_req;
        if (any_req) state_nxt = CFG;
      end
      CFG: begin
        ctrl_val = 1'b1;
        ctrl_msg = BIT_WIDTH'(pack_ctrl(BIT_WIDTH, ADDRESS_BIT_WIDTH, IN_W, OUT_W,
                                        BLOCK_ADDRESS, 32'(in_sel), 32'(out_sel)));
        if (ctrl_rdy) state_nxt = XFER;
      end
      XFER: begin
        if (last || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      in_sel  <= '0;
      out_sel <= '0;
      done    <= '0;
    end else begin
      state <= state_nxt;
      done  <= '0;
      if (state == IDLE && any_req) begin
        in_sel  <= grant_idx;
        out_sel <= req_dest[grant_idx];
        cnt     <= (req_len[grant_idx] == '0) ? LEN_BITS'(1) : req_len[grant_idx];
      end
      if (fire) cnt <= cnt - 1'b1;
      if (last || abort) done[in_sel] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_route_scheduler.sv
// Directed bench for xbar_route_scheduler (2 inputs, 2 outputs, 32-bit control word).
module tb_xbar_route_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_val;
  logic [1:0] req_rdy;
  logic [0:0] req_dest [2];
  logic [7:0] req_len  [2];
  logic [31:0] ctrl_msg;
  logic       ctrl_val;
  logic       ctrl_rdy;
  logic [1:0] out_fire;
  logic [1:0] done;
  logic       busy;
`ifdef XBAR_SCHED_TIMEOUT_EN
  logic       timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xbar_route_scheduler #(
    .BIT_WIDTH         (32),
    .N_INPUTS          (2),
    .N_OUTPUTS         (2),
    .ADDRESS_BIT_WIDTH (4),
    .BLOCK_ADDRESS     (2),
    .LEN_BITS          (8)
`ifdef XBAR_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT           (4)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_dest (req_dest),
    .req_len  (req_len),
    .ctrl_msg (ctrl_msg),
    .ctrl_val (ctrl_val),
    .ctrl_rdy (ctrl_rdy),
    .out_fire (out_fire),
    .done     (done),
`ifdef XBAR_SCHED_TIMEOUT_EN
    .timeout  (timeout),
`endif
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req_val  = '0;
    out_fire = '0;
    ctrl_rdy = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_dest[0] = '0; req_dest[1] = '0;
    req_len[0]  = '0; req_len[1]  = '0;

    // 1: single burst dest=1 len=3
    do_reset();
    check("rst_req_rdy", req_rdy, 2'b00);
    check("rst_ctrl_val", ctrl_val, 1'b0);
    check("rst_ctrl_msg", ctrl_msg, 32'h0);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    req_dest[0] = 1'b1; req_len[0] = 8'd3; ctrl_rdy = 1'b1; req_val = 2'b01;
    #1;
    check("t1_grant", req_rdy, 2'b01);
    step();
    req_val = 2'b00;
    check("t1_ctrl_val", ctrl_val, 1'b1);
    check("t1_ctrl_msg", ctrl_msg, 32'h2A00_0000);
    check("t1_rdy_cfg", req_rdy, 2'b00);
    check("t1_busy_cfg", busy, 1'b1);
    step();
    check("t1_ctrl_val_xfer", ctrl_val, 1'b0);
    check("t1_busy_xfer", busy, 1'b1);
    out_fire = 2'b10;
    step();
    check("t1_done_f1", done, 2'b00);
    step();
    check("t1_done_f2", done, 2'b00);
    step();
    out_fire = 2'b00;
    check("t1_done_pulse", done, 2'b01);
    check("t1_busy_idle", busy, 1'b0);
    step();
    check("t1_done_clear", done, 2'b00);

    // 2: two contenders, len=1, grants alternate
    do_reset();
    req_len[0] = 8'd1; req_len[1] = 8'd1;
    req_dest[0] = 1'b0; req_dest[1] = 1'b0;
    ctrl_rdy = 1'b1; out_fire = 2'b01; req_val = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_grant", req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
      check("t2_ctrl_msg", ctrl_msg, (k % 2 == 0) ? 32'h2800_0000 : 32'h2C00_0000);
      step();
      step();
      check("t2_done", done, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    req_val = 2'b00; out_fire = 2'b00;

    // 3: crossbar holds off the control word
    do_reset();
    req_dest[0] = 1'b0; req_len[0] = 8'd1; out_fire = 2'b01; req_val = 2'b01;
    #1;
    check("t3_grant", req_rdy, 2'b01);
    for (int i = 0; i < 5; i++) begin
      step();
      req_val = 2'b00;
      check("t3_ctrl_val_hold", ctrl_val, 1'b1);
      check("t3_ctrl_msg_hold", ctrl_msg, 32'h2800_0000);
      check("t3_done_cfg", done, 2'b00);
      if (i == 4) ctrl_rdy = 1'b1;
    end
    step();
    check("t3_ctrl_val_xfer", ctrl_val, 1'b0);
    check("t3_busy_xfer", busy, 1'b1);
    step();
    check("t3_done", done, 2'b01);
    check("t3_busy_idle", busy, 1'b0);
    out_fire = 2'b00;

    // 4: len=0 means one message; other output's fires ignored
    do_reset();
    ctrl_rdy = 1'b1; req_dest[1] = 1'b1; req_len[1] = 8'd0; req_val = 2'b10;
    #1;
    check("t4_grant", req_rdy, 2'b10);
    step();
    req_val = 2'b00;
    check("t4_ctrl_msg", ctrl_msg, 32'h2E00_0000);
    out_fire = 2'b01;
    step();
    check("t4_busy_x1", busy, 1'b1);
    step();
    check("t4_busy_x2", busy, 1'b1);
    check("t4_done_x2", done, 2'b00);
    out_fire = 2'b10;
    step();
    out_fire = 2'b00;
    check("t4_done", done, 2'b10);
    check("t4_busy_idle", busy, 1'b0);
    step();
    check("t4_done_clear", done, 2'b00);

    // 5: reset in XFER with cnt=2
    do_reset();
    ctrl_rdy = 1'b1; req_dest[0] = 1'b1; req_len[0] = 8'd3; req_val = 2'b01;
    #1;
    step();
    req_val = 2'b00;
    step();
    out_fire = 2'b10;
    step();
    out_fire = 2'b00;
    reset = 1'b1;
    step();
    check("t5_busy", busy, 1'b0);
    check("t5_ctrl_val", ctrl_val, 1'b0);
    check("t5_ctrl_msg", ctrl_msg, 32'h0);
    check("t5_done", done, 2'b00);
    check("t5_req_rdy", req_rdy, 2'b00);
    reset = 1'b0;
    step();
    check("t5_done_after", done, 2'b00);
    req_val = 2'b11;
    #1;
    check("t5_ptr_reset", req_rdy, 2'b01);
    req_val = 2'b00;

`ifdef XBAR_SCHED_TIMEOUT_EN
    // 6: no fires in XFER -> timeout after 4 idle cycles
    do_reset();
    ctrl_rdy = 1'b1; req_dest[0] = 1'b0; req_len[0] = 8'd2; req_val = 2'b01;
    #1;
    step();
    req_val = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_busy_wait", busy, 1'b1);
      check("t6_timeout_low", timeout, 1'b0);
      check("t6_done_low", done, 2'b00);
    end
    step();
    check("t6_timeout", timeout, 1'b1);
    check("t6_done", done, 2'b01);
    check("t6_busy", busy, 1'b0);
    step();
    check("t6_timeout_clear", timeout, 1'b0);
    check("t6_done_clear", done, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
